// File: rtl/pwm_multichannel_core.sv
// Multi-channel PWM generator sharing one period counter, with per-channel duty, polarity and
// edge/center alignment. Define PWM_SHADOW_EN for boundary-synchronous (shadowed) config updates.
module pwm_multichannel_core #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 10,
  parameter int unsigned CHW = 4
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           tick_en,
  input  logic [CW-1:0]  period_in,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_duty,
  input  logic           cfg_pol,
  input  logic           cfg_center,
  output logic           cfg_err,
  output logic           period_stb,
  output logic [NCH-1:0] pwm_out
);

  logic [CW-1:0]           cnt_q, cnt_d, per_q, per_d, per_req;
  logic [NCH-1:0][CW-1:0]  duty_q, duty_d;
  logic [NCH-1:0]          pol_q, pol_d, ctr_q, ctr_d;
  logic [NCH-1:0]          on, pwm_q, pwm_d;
  logic                    err_q, stb_q;
  logic                    wrap, cfg_acc, ch_ok;

  assign per_req = (period_in < CW'(2)) ? CW'(2) : period_in;
  assign wrap    = tick_en && (cnt_q == per_q - CW'(1));
  assign ch_ok   = (32'(cfg_ch) < NCH);
  assign cfg_acc = cfg_valid && cfg_ready;

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (wrap) begin
      cnt_d = '0;
      per_d = per_req;
    end else if (tick_en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [NCH-1:0][CW-1:0]  sh_duty_q, sh_duty_d;
  logic [NCH-1:0]          sh_pol_q, sh_pol_d, sh_ctr_q, sh_ctr_d, pend_q, pend_d;
  logic [(2**CHW)-1:0]     pend_ext;

  // Out-of-range channels read as not pending so the write is accepted and flagged.
  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = pend_q;
  end

  assign cfg_ready = !reset && !pend_ext[cfg_ch];

  // Boundary loads use the old shadow; a same-cycle write queues for the next boundary.
  always_comb begin
    duty_d    = duty_q;
    pol_d     = pol_q;
    ctr_d     = ctr_q;
    sh_duty_d = sh_duty_q;
    sh_pol_d  = sh_pol_q;
    sh_ctr_d  = sh_ctr_q;
    pend_d    = pend_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (wrap && pend_q[i]) begin
        duty_d[i] = sh_duty_q[i];
        pol_d[i]  = sh_pol_q[i];
        ctr_d[i]  = sh_ctr_q[i];
        pend_d[i] = 1'b0;
      end
      if (cfg_acc && ch_ok && (cfg_ch == CHW'(i))) begin
        sh_duty_d[i] = cfg_duty;
        sh_pol_d[i]  = cfg_pol;
        sh_ctr_d[i]  = cfg_center;
        pend_d[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sh_duty_q <= '0;
      sh_pol_q  <= '1;
      sh_ctr_q  <= '0;
      pend_q    <= '0;
    end else begin
      sh_duty_q <= sh_duty_d;
      sh_pol_q  <= sh_pol_d;
      sh_ctr_q  <= sh_ctr_d;
      pend_q    <= pend_d;
    end
  end
`else
  assign cfg_ready = !reset;

  always_comb begin
    duty_d = duty_q;
    pol_d  = pol_q;
    ctr_d  = ctr_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cfg_acc && ch_ok && (cfg_ch == CHW'(i))) begin
        duty_d[i] = cfg_duty;
        pol_d[i]  = cfg_pol;
        ctr_d[i]  = cfg_center;
      end
    end
  end
`endif

  // Compare in CW+1 bits so lo+D cannot overflow.
  always_comb begin
    logic [CW:0] per_w, cnt_w, d_eff, lo, hi;
    per_w = {1'b0, per_q};
    cnt_w = {1'b0, cnt_q};
    on    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      d_eff = ({1'b0, duty_q[i]} < per_w) ? {1'b0, duty_q[i]} : per_w;
      lo    = (per_w - d_eff) >> 1;
      hi    = lo + d_eff;
      if (ctr_q[i]) begin
        on[i] = (cnt_w >= lo) && (cnt_w < hi);
      end else begin
        on[i] = (cnt_w < d_eff);
      end
    end
  end

  assign pwm_d = on ^ ~pol_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q  <= '0;
      per_q  <= per_req;
      duty_q <= '0;
      pol_q  <= '1;
      ctr_q  <= '0;
      pwm_q  <= '0;
      err_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      duty_q <= duty_d;
      pol_q  <= pol_d;
      ctr_q  <= ctr_d;
      pwm_q  <= pwm_d;
      err_q  <= cfg_acc && !ch_ok;
      stb_q  <= wrap;
    end
  end

  assign pwm_out    = pwm_q;
  assign cfg_err    = err_q;
  assign period_stb = stb_q;

endmodule
